// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: ALU result bus, register index and writeback buffer entry.
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH   = 128;
    localparam int RISCV_V_NUM_BYTES    = RISCV_V_DATA_WIDTH / 8;
    localparam int RISCV_V_NUM_VREGS    = 32;
    localparam int RISCV_V_WB_BUF_DEPTH = 4;

    typedef struct packed {
        logic [RISCV_V_DATA_WIDTH-1:0] data;
        logic                          valid;
    } riscv_v_wb_data_t;

    typedef logic [$clog2(RISCV_V_NUM_VREGS)-1:0] riscv_v_vreg_idx_t;

    typedef struct packed {
        logic [RISCV_V_DATA_WIDTH-1:0] data;
        logic [RISCV_V_NUM_BYTES-1:0]  be;
        riscv_v_vreg_idx_t             vd;
    } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// In-order DEPTH-entry store of writeback entries; full/empty tracked by occupancy.
module riscv_v_wb_fifo
    import riscv_v_pkg::*;
#(
    parameter int DEPTH = RISCV_V_WB_BUF_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic                                pop,
    input  riscv_v_wb_entry_t                   push_entry,
    output riscv_v_wb_entry_t                   head_entry,
    output logic [$clog2(DEPTH):0]              occupancy,
    output logic [DEPTH-1:0]                    entry_valid,
    output riscv_v_vreg_idx_t [DEPTH-1:0]       entry_vd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    riscv_v_wb_entry_t  mem_q [DEPTH];
    riscv_v_wb_entry_t  mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               push_ok, pop_ok;

    // Guards keep the store consistent even if a caller ignores full/empty.
    assign push_ok = push && (occ_q != OCC_W'(DEPTH));
    assign pop_ok  = pop && (occ_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        occ_d    = occ_q;
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_vd[i] = mem_q[i].vd;
        end
    end

    assign head_entry  = mem_q[rd_ptr_q];
    assign occupancy   = occ_q;
    assign entry_valid = valid_q;

endmodule

// File: rtl/riscv_v_wb_buffer.sv
// Writeback buffer between the vector ALU result bus and the VRF write port,
// with occupancy and per-register pending-write outputs for issue-stage hazard checks.
module riscv_v_wb_buffer
    import riscv_v_pkg::*;
#(
    parameter int DEPTH     = RISCV_V_WB_BUF_DEPTH,
    parameter int NUM_VREGS = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  riscv_v_wb_data_t               wb_in,
    input  logic [$clog2(NUM_VREGS)-1:0]   wb_vd,
    input  logic [RISCV_V_NUM_BYTES-1:0]   wb_be,
    output logic                           wb_ready,
    output logic                           vrf_we,
    output logic [$clog2(NUM_VREGS)-1:0]   vrf_addr,
    output logic [RISCV_V_DATA_WIDTH-1:0]  vrf_wdata,
    output logic [RISCV_V_NUM_BYTES-1:0]   vrf_be,
    input  logic                           vrf_ready,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic [NUM_VREGS-1:0]           pending_vd
);

    localparam int VD_W  = $clog2(NUM_VREGS);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                          push, pop;
    riscv_v_wb_entry_t             push_entry, head_entry;
    logic [DEPTH-1:0]              entry_valid;
    riscv_v_vreg_idx_t [DEPTH-1:0] entry_vd;

    // Handshakes: a transfer happens on a clk edge where valid and ready are both 1.
    // wb_ready depends on held state only; vrf_we never waits on vrf_ready, and the
    // head entry stays on vrf_* until it is accepted.
    assign wb_ready = (occupancy < OCC_W'(DEPTH));
    assign push     = wb_in.valid && wb_ready && (wb_be != '0);
    assign vrf_we   = (occupancy != '0);
    assign pop      = vrf_we && vrf_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.data = wb_in.data;
        push_entry.be   = wb_be;
        push_entry.vd   = riscv_v_vreg_idx_t'(wb_vd);
    end

    riscv_v_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .push_entry  (push_entry),
        .head_entry  (head_entry),
        .occupancy   (occupancy),
        .entry_valid (entry_valid),
        .entry_vd    (entry_vd)
    );

    // Gating by vrf_we keeps stale or uninitialised storage off the VRF port.
    always_comb begin
        vrf_addr  = '0;
        vrf_wdata = '0;
        vrf_be    = '0;
        if (vrf_we) begin
            vrf_addr  = VD_W'(head_entry.vd);
            vrf_wdata = head_entry.data;
            vrf_be    = head_entry.be;
        end
    end

    always_comb begin
        pending_vd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_vd[VD_W'(entry_vd[i])] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_wb_buffer.sv
// Bench for riscv_v_wb_buffer: stepped vector table, wrap-around streaming and
// mid-traffic reset, with a queue scoreboard watching every VRF write.
module tb_riscv_v_wb_buffer;
    import riscv_v_pkg::*;

    localparam int DEPTH = 4;
    localparam int EW    = 5 + RISCV_V_NUM_BYTES + RISCV_V_DATA_WIDTH;

    logic                          clk;
    logic                          rst_n;
    riscv_v_wb_data_t              wb_in;
    logic [4:0]                    wb_vd;
    logic [RISCV_V_NUM_BYTES-1:0]  wb_be;
    logic                          wb_ready;
    logic                          vrf_we;
    logic [4:0]                    vrf_addr;
    logic [RISCV_V_DATA_WIDTH-1:0] vrf_wdata;
    logic [RISCV_V_NUM_BYTES-1:0]  vrf_be;
    logic                          vrf_ready;
    logic [2:0]                    occupancy;
    logic [31:0]                   pending_vd;

    riscv_v_wb_buffer #(
        .DEPTH     (DEPTH),
        .NUM_VREGS (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_in      (wb_in),
        .wb_vd      (wb_vd),
        .wb_be      (wb_be),
        .wb_ready   (wb_ready),
        .vrf_we     (vrf_we),
        .vrf_addr   (vrf_addr),
        .vrf_wdata  (vrf_wdata),
        .vrf_be     (vrf_be),
        .vrf_ready  (vrf_ready),
        .occupancy  (occupancy),
        .pending_vd (pending_vd)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pops_total = 0;
    bit stream_on = 1'b0;

    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0]   mon_pend;
    logic [EW-1:0] mon_head;
    int            mon_sz;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            mon_sz   = exp_q.size();
            mon_pend = '0;
            foreach (exp_q[i]) mon_pend[exp_q[i][EW-1 -: 5]] = 1'b1;
            chk("sb_occupancy", occupancy, mon_sz);
            chk("sb_wb_ready", wb_ready, mon_sz < DEPTH);
            chk("sb_vrf_we", vrf_we, mon_sz != 0);
            chk("sb_pending_vd", pending_vd, mon_pend);
            if (mon_sz == 0) begin
                chk("sb_idle_vrf", {vrf_addr, vrf_be, vrf_wdata}, '0);
            end else if (vrf_ready) begin
                mon_head = exp_q.pop_front();
                pops_total++;
                chk("sb_vrf_addr", vrf_addr, mon_head[EW-1 -: 5]);
                chk("sb_vrf_be", vrf_be, mon_head[RISCV_V_DATA_WIDTH +: RISCV_V_NUM_BYTES]);
                chk("sb_vrf_wdata", vrf_wdata, mon_head[RISCV_V_DATA_WIDTH-1:0]);
            end
            if (wb_in.valid && mon_sz < DEPTH && wb_be != '0) begin
                exp_q.push_back({wb_vd, wb_be, wb_in.data});
            end
        end
    end

    // ---------------- driver tasks ----------------
    always @(posedge clk) begin
        if (stream_on) begin
            #1;
            vrf_ready = ~vrf_ready;
        end
    end

    task automatic push_one(input logic [4:0] vd, input logic [15:0] be,
                            input logic [127:0] d);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        wb_in.valid = 1'b1;
        wb_vd       = vd;
        wb_be       = be;
        wb_in.data  = d;
        while (!done) begin
            done = wb_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                fail_now("push_accept");
                break;
            end
        end
        wb_in.valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [4:0]  vd;
        logic [15:0] be;
        logic [7:0]  db;
        logic        rdy;
        logic [2:0]  exp_occ;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int n;

        rst_n       = 1'b0;
        wb_in       = '0;
        wb_vd       = '0;
        wb_be       = '0;
        vrf_ready   = 1'b0;

        // fill with vrf_ready=0, 5th refused, full+pop, drain in order
        tbl[0]  = '{1'b1, 5'd1, 16'hFFFF, 8'h11, 1'b0, 3'd1, 32'h0000_0002};
        tbl[1]  = '{1'b1, 5'd2, 16'hFFFF, 8'h22, 1'b0, 3'd2, 32'h0000_0006};
        tbl[2]  = '{1'b1, 5'd3, 16'hFFFF, 8'h33, 1'b0, 3'd3, 32'h0000_000E};
        tbl[3]  = '{1'b1, 5'd4, 16'hFFFF, 8'h44, 1'b0, 3'd4, 32'h0000_001E};
        tbl[4]  = '{1'b1, 5'd5, 16'hFFFF, 8'h55, 1'b0, 3'd4, 32'h0000_001E};
        tbl[5]  = '{1'b1, 5'd5, 16'hFFFF, 8'h55, 1'b1, 3'd3, 32'h0000_001C};
        tbl[6]  = '{1'b1, 5'd5, 16'hFFFF, 8'h55, 1'b0, 3'd4, 32'h0000_003C};
        tbl[7]  = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd3, 32'h0000_0038};
        tbl[8]  = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd2, 32'h0000_0030};
        tbl[9]  = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd1, 32'h0000_0020};
        tbl[10] = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd0, 32'h0000_0000};
        // same vd twice, then a zero-BE result
        tbl[11] = '{1'b1, 5'd7, 16'h00FF, 8'h77, 1'b0, 3'd1, 32'h0000_0080};
        tbl[12] = '{1'b1, 5'd7, 16'hFF00, 8'h78, 1'b0, 3'd2, 32'h0000_0080};
        tbl[13] = '{1'b1, 5'd9, 16'h0000, 8'h99, 1'b0, 3'd2, 32'h0000_0080};
        tbl[14] = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd1, 32'h0000_0080};
        tbl[15] = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd0, 32'h0000_0000};
        // single write with VRF ready
        tbl[16] = '{1'b1, 5'd5, 16'hFFFF, 8'hA5, 1'b1, 3'd1, 32'h0000_0020};
        tbl[17] = '{1'b0, 5'd0, 16'h0000, 8'h00, 1'b1, 3'd0, 32'h0000_0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_ready", wb_ready, 1'b1);
        chk("rst_vrf_we", vrf_we, 1'b0);
        chk("rst_vrf_port", {vrf_addr, vrf_be, vrf_wdata}, '0);
        chk("rst_occupancy", occupancy, 3'd0);
        chk("rst_pending_vd", pending_vd, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            wb_in.valid = tbl[i].v;
            wb_vd       = tbl[i].vd;
            wb_be       = tbl[i].be;
            wb_in.data  = {16{tbl[i].db}};
            vrf_ready   = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].exp_occ);
            chk($sformatf("tbl%0d_pend", i), pending_vd, tbl[i].exp_pend);
        end
        wb_in.valid = 1'b0;

        // streaming with toggling back-pressure; pointers wrap several times
        stream_on = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            push_one(5'(k + 8), 16'($urandom_range(1, 16'hFFFF)), d);
        end
        stream_on = 1'b0;
        #2;
        vrf_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) fail_now("stream_drain");
        @(posedge clk);
        #1;
        chk("stream_occ", occupancy, 3'd0);
        chk("pops_total", pops_total, 28);

        // reset with three entries held
        vrf_ready = 1'b0;
        push_one(5'd10, 16'hFFFF, 128'h1010);
        push_one(5'd11, 16'hFFFF, 128'h1111);
        push_one(5'd12, 16'hFFFF, 128'h1212);
        chk("pre_rst_occ", occupancy, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_occ", occupancy, 3'd0);
        chk("mid_rst_vrf_we", vrf_we, 1'b0);
        chk("mid_rst_pending", pending_vd, 32'h0);
        chk("mid_rst_wb_ready", wb_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        vrf_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_pops", pops_total, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
